// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, one-hot registered grant held until done.
// Optional watchdog (`ARB_TIMEOUT_EN) force-releases a grant after TIMEOUT cycles.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   req     in   [N_REQ]  level request per requester
//   done    in   resource completion pulse, sampled only while busy
//   gnt     out  [N_REQ]  one-hot grant, zero when idle
//   gnt_id  out  [IDW]    index of granted requester, held when idle
//   busy    out  grant active
//   timeout out  one-cycle pulse after a watchdog release

module rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8,
    localparam int IDW    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_n;
    logic [IDW-1:0]   r_gnt_id;
    logic [IDW-1:0]   w_gnt_id_n;
    logic             r_busy;
    logic             w_busy_n;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   w_ptr_n;
    logic [IDW-1:0]   w_rel_ptr;
    logic [IDW:0]     w_pick_idle;
    logic [IDW:0]     w_pick_rel;
    logic             w_expire;
    logic             w_release;
    logic             w_grant_new;

    // First requester at or after p, wrapping modulo N_REQ.
    // MSB of the result flags a valid winner.
    function automatic logic [IDW:0] f_pick(
        input logic [N_REQ-1:0] i_r,
        input logic [IDW-1:0]   i_p
    );
        logic [IDW:0] v_res;
        logic [IDW:0] v_sum;
        v_res = '0;
        // Scan from the far end so the nearest hit is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            v_sum = {1'b0, i_p} + (IDW+1)'(k);
            if (v_sum >= (IDW+1)'(N_REQ))
                v_sum = v_sum - (IDW+1)'(N_REQ);
            if (i_r[v_sum[IDW-1:0]])
                v_res = {1'b1, v_sum[IDW-1:0]};
        end
        return v_res;
    endfunction

    assign w_rel_ptr = (r_gnt_id == IDW'(N_REQ - 1)) ? '0
                     : r_gnt_id + IDW'(1);

    assign w_pick_idle = f_pick(req, r_ptr);
    assign w_pick_rel  = f_pick(req, w_rel_ptr);

    assign w_release = (r_state == S_BUSY) && (done || w_expire);

    always_comb begin
        w_state_n   = r_state;
        w_gnt_n     = r_gnt;
        w_gnt_id_n  = r_gnt_id;
        w_busy_n    = r_busy;
        w_ptr_n     = r_ptr;
        w_grant_new = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_pick_idle[IDW]) begin
                    w_state_n   = S_BUSY;
                    w_gnt_n     = N_REQ'(1) << w_pick_idle[IDW-1:0];
                    w_gnt_id_n  = w_pick_idle[IDW-1:0];
                    w_busy_n    = 1'b1;
                    w_grant_new = 1'b1;
                end
            end
            S_BUSY: begin
                if (w_release) begin
                    w_ptr_n = w_rel_ptr;
                    // Back-to-back handoff when someone else waits.
                    if (w_pick_rel[IDW]) begin
                        w_gnt_n     = N_REQ'(1) << w_pick_rel[IDW-1:0];
                        w_gnt_id_n  = w_pick_rel[IDW-1:0];
                        w_grant_new = 1'b1;
                    end else begin
                        w_state_n = S_IDLE;
                        w_gnt_n   = '0;
                        w_busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_busy   <= 1'b0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_n;
            r_gnt    <= w_gnt_n;
            r_gnt_id <= w_gnt_id_n;
            r_busy   <= w_busy_n;
            r_ptr    <= w_ptr_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [TO_W-1:0] r_cnt;
    logic            r_timeout;

    // done in the same cycle wins: no forced release, no pulse.
    assign w_expire = (r_state == S_BUSY) && !done
                   && (r_cnt == TO_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (w_grant_new)
                r_cnt <= TO_W'(1);
            else if ((r_state == S_BUSY) && !w_release)
                r_cnt <= r_cnt + TO_W'(1);
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;

    // Watchdog parameters have no effect in this build.
    if (TIMEOUT < 1 || TO_W < 1) begin : g_wd_unused
    end
`endif

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = r_busy;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed checks of rr_arbiter with N_REQ=4, TIMEOUT=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter #(
        .N_REQ  (4),
        .TIMEOUT(8),
        .TO_W   (8)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        repeat (2) tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_id", 32'(gnt_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_to", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        tick();

        // First grant from reset pointer 0.
        req = 4'b0101;
        tick();
        chk("g0_gnt", 32'(gnt), 32'h1);
        chk("g0_id", 32'(gnt_id), 32'h0);
        chk("g0_busy", 32'(busy), 32'h1);

        // done hands off to 2, then back to 0 with no idle gap.
        done = 1'b1;
        tick();
        chk("g2_gnt", 32'(gnt), 32'h4);
        chk("g2_id", 32'(gnt_id), 32'h2);
        tick();
        chk("g0b_gnt", 32'(gnt), 32'h1);
        chk("g0b_busy", 32'(busy), 32'h1);

        // Full rotation with all requesting.
        req = 4'b1111;
        tick();
        chk("rot1", 32'(gnt), 32'h2);
        tick();
        chk("rot2", 32'(gnt), 32'h4);
        tick();
        chk("rot3", 32'(gnt), 32'h8);
        tick();
        chk("rot0", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        chk("idle_gnt", 32'(gnt), 32'h0);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_id", 32'(gnt_id), 32'h0);
        done = 1'b0;

        // Stuck transaction on requester 1 (ptr is 1 here).
        req = 4'b0010;
        tick();
        chk("wd_g1", 32'(gnt), 32'h2);
        req = 4'b0000;
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk($sformatf("wd_hold%0d", c), 32'(gnt), 32'h2);
            chk($sformatf("wd_to%0d", c), 32'(timeout), 32'h0);
        end
        tick();
        chk("wd_rel_gnt", 32'(gnt), 32'h0);
        chk("wd_rel_busy", 32'(busy), 32'h0);
        chk("wd_pulse", 32'(timeout), 32'h1);
        tick();
        chk("wd_pulse_end", 32'(timeout), 32'h0);
`else
        for (int c = 2; c <= 22; c++) begin
            tick();
            chk($sformatf("nowd_hold%0d", c), 32'(gnt), 32'h2);
            chk($sformatf("nowd_to%0d", c), 32'(timeout), 32'h0);
        end
        done = 1'b1;
        tick();
        chk("nowd_rel", 32'(gnt), 32'h0);
        done = 1'b0;
        tick();
`endif

        // done on the 8th busy cycle is a normal completion (ptr is 2).
        req = 4'b0010;
        tick();
        chk("d8_g1", 32'(gnt), 32'h2);
        req = 4'b0000;
        repeat (7) tick();
        chk("d8_hold", 32'(gnt), 32'h2);
        done = 1'b1;
        tick();
        chk("d8_rel", 32'(gnt), 32'h0);
        chk("d8_to", 32'(timeout), 32'h0);
        done = 1'b0;
        tick();
        chk("d8_to_after", 32'(timeout), 32'h0);

        // done while idle must not move the pointer.
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("idone_gnt", 32'(gnt), 32'h0);
        chk("idone_busy", 32'(busy), 32'h0);
        req = 4'b1111;
        tick();
        chk("idone_next", 32'(gnt), 32'h4);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("pre_rst", 32'(gnt), 32'h8);

        // Asynchronous reset mid-transaction.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_id", 32'(gnt_id), 32'h0);
        req = 4'b1001;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ptr0_gnt", 32'(gnt), 32'h1);
        chk("ptr0_id", 32'(gnt_id), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
